// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared state/line encodings and default limits for the USB receive deserializer
package usb_rx_pkg;
  localparam int DEF_STUFF_LIMIT = 6;
  localparam int DEF_EOP_SE0_MIN = 2;
  typedef enum logic [1:0] {IDLE, RECV, EOP, ERR_WAIT} state_t;
  typedef enum logic [1:0] {LS_NONE, LS_J, LS_K, LS_SE0} line_t;
  function automatic line_t line_decode(input logic j, input logic k, input logic se0);
    return se0 ? LS_SE0 : (j && !k) ? LS_J : (k && !j) ? LS_K : LS_NONE;
  endfunction
endpackage

// File: rtl/usb_rx_if.sv
// usb_rx_if: line-sample inputs and UTMI-style receive outputs of the deserializer
interface usb_rx_if;
  logic       rx_en;
  logic       sample;
  logic       J;
  logic       K;
  logic       SE0;
  logic       S_det;
  logic [7:0] data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_error;
  logic       eop_det;
  modport master (
    output rx_en, sample, J, K, SE0, S_det,
    input  data, rx_valid, rx_active, rx_error, eop_det
  );
  modport slave (
    input  rx_en, sample, J, K, SE0, S_det,
    output data, rx_valid, rx_active, rx_error, eop_det
  );
endinterface

// File: rtl/usb_nrzi_unstuff.sv
// usb_nrzi_unstuff: NRZI decode of J/K samples with stuff-bit removal and stuff-error detection
module usb_nrzi_unstuff import usb_rx_pkg::*; #(
  parameter int STUFF_LIMIT = DEF_STUFF_LIMIT
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  sample,
  input  line_t line,
  input  logic  start,
  output logic  bit_valid,
  output logic  rx_bit,
  output logic  stuff_err
);
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  line_t         prev_q, prev_d;
  logic [OW-1:0] ones_q, ones_d;
  logic          jk, at_lim;
  always_comb begin
    jk        = sample && (line == LS_J || line == LS_K);
    at_lim    = ones_q == OW'(STUFF_LIMIT);
    rx_bit    = line == prev_q;
    bit_valid = jk && !at_lim;
    stuff_err = jk && at_lim && rx_bit;
    prev_d    = start ? LS_K : jk ? line : prev_q;
    // the last SYNC symbol is a decoded one, so the run starts at 1
    ones_d    = start ? OW'(1) : !jk ? ones_q : (rx_bit && !at_lim) ? ones_q + 1'b1 : '0;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      prev_q <= LS_K;
      ones_q <= '0;
    end else begin
      prev_q <= prev_d;
      ones_q <= ones_d;
    end
endmodule

// File: rtl/usb_rx_deserializer.sv
// usb_rx_deserializer: post-SYNC receive path assembling LSB-first bytes and detecting EOP
module usb_rx_deserializer import usb_rx_pkg::*; #(
  parameter int STUFF_LIMIT = DEF_STUFF_LIMIT,
  parameter int EOP_SE0_MIN = DEF_EOP_SE0_MIN
) (
  input logic     CLK,
  input logic     RST,
  usb_rx_if.slave bus
);
  localparam int SW = $clog2(EOP_SE0_MIN + 1);
  state_t        state_q, state_d;
  logic [7:0]    shreg_q, shreg_d, data_q, data_d, byte_w;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [SW-1:0] se0_cnt_q, se0_cnt_d;
  logic          rx_valid_q, rx_valid_d, rx_active_q, rx_active_d;
  logic          rx_error_q, rx_error_d, eop_det_q, eop_det_d;
  line_t         line;
  logic          start, bit_valid, rx_bit, stuff_err, se0_s, j_s, k_s;
  assign line  = line_decode(bus.J, bus.K, bus.SE0);
  assign se0_s = bus.sample && line == LS_SE0;
  assign j_s   = bus.sample && line == LS_J;
  assign k_s   = bus.sample && line == LS_K;
  assign start = bus.rx_en && bus.S_det && state_q == IDLE;
  usb_nrzi_unstuff #(.STUFF_LIMIT(STUFF_LIMIT)) u_unstuff (
    .CLK       (CLK),
    .RST       (RST),
    .sample    (bus.sample),
    .line      (line),
    .start     (start),
    .bit_valid (bit_valid),
    .rx_bit    (rx_bit),
    .stuff_err (stuff_err)
  );
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    se0_cnt_d   = se0_cnt_q;
    data_d      = data_q;
    rx_active_d = rx_active_q;
    rx_valid_d  = 1'b0;
    rx_error_d  = 1'b0;
    eop_det_d   = 1'b0;
    byte_w      = {rx_bit, shreg_q[7:1]};
    if (!bus.rx_en) begin
      state_d     = IDLE;
      rx_active_d = 1'b0;
    end else begin
      case (state_q)
        IDLE:
          if (bus.S_det) begin
            state_d     = RECV;
            rx_active_d = 1'b1;
            bit_cnt_d   = '0;
          end
        RECV:
          if (se0_s) begin
            state_d    = EOP;
            se0_cnt_d  = SW'(1);
            rx_error_d = bit_cnt_q != 3'd0;
          end else if (stuff_err) begin
            state_d    = ERR_WAIT;
            rx_error_d = 1'b1;
          end else if (bit_valid) begin
            shreg_d    = byte_w;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            rx_valid_d = bit_cnt_q == 3'd7;
            data_d     = bit_cnt_q == 3'd7 ? byte_w : data_q;
          end
        EOP:
          if (se0_s) begin
            se0_cnt_d = se0_cnt_q == SW'(EOP_SE0_MIN) ? se0_cnt_q : se0_cnt_q + 1'b1;
          end else if (j_s && se0_cnt_q >= SW'(EOP_SE0_MIN)) begin
            state_d     = IDLE;
            rx_active_d = 1'b0;
            eop_det_d   = 1'b1;
          end else if (j_s || k_s) begin
            state_d    = ERR_WAIT;
            rx_error_d = 1'b1;
          end
        ERR_WAIT:
          if (se0_s) begin
            state_d   = EOP;
            se0_cnt_d = SW'(1);
          end
      endcase
    end
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      se0_cnt_q   <= '0;
      data_q      <= '0;
      rx_valid_q  <= 1'b0;
      rx_active_q <= 1'b0;
      rx_error_q  <= 1'b0;
      eop_det_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      se0_cnt_q   <= se0_cnt_d;
      data_q      <= data_d;
      rx_valid_q  <= rx_valid_d;
      rx_active_q <= rx_active_d;
      rx_error_q  <= rx_error_d;
      eop_det_q   <= eop_det_d;
    end
  assign bus.data      = data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_active = rx_active_q;
  assign bus.rx_error  = rx_error_q;
  assign bus.eop_det   = eop_det_q;
endmodule

// File: doc/usb_rx_deserializer.md
Name: usb_rx_deserializer

Overview:
- Receive-path stage directly downstream of the sync-detect FSM; starts when it pulses S_det.
- Consumes the sampled line state (sample strobe plus J/K/SE0) and NRZI-decodes it.
- Removes stuffed bits, assembles bytes LSB-first and detects EOP.
- Presents UTMI-style rx_active / rx_valid / data / rx_error to the packet layer.

Parameters:
STUFF_LIMIT, 6, consecutive decoded ones after which the next bit is a stuff bit.
EOP_SE0_MIN, 2, minimum SE0 samples before J that form a valid EOP.

Ports:
CLK  in  1  system clock.
RST  in  1  asynchronous, active-low reset.
rx_en  in  1  receive enable; low forces IDLE synchronously.
sample  in  1  one-cycle strobe: the line state inputs are valid this cycle.
J  in  1  line state J (qualified by sample).
K  in  1  line state K (qualified by sample).
SE0  in  1  single-ended zero (qualified by sample); priority over J/K.
S_det  in  1  one-cycle pulse: SYNC complete, last sync symbol was K.
data  out  8  received byte, valid while rx_valid=1.
rx_valid  out  1  one-cycle pulse, new byte on data.
rx_active  out  1  high from the cycle after S_det until the cycle after EOP completes.
rx_error  out  1  one-cycle pulse: stuff error, partial byte at EOP, or bad EOP.
eop_det  out  1  one-cycle pulse at EOP completion.

Behaviour:
- Reset values: data=8'h00; rx_valid=0; rx_active=0; rx_error=0; eop_det=0; state=IDLE.
- Internal reset values: prev_line=K, ones_cnt=0, bit_cnt=0, se0_cnt=0.
- A sample cycle with none of J/K/SE0, or with J&K both high, is ignored (no state change).
- IDLE:
  - On S_det with rx_en=1: go to RECV, rx_active<=1, prev_line<=K.
  - Also on S_det: ones_cnt<=1 (the final sync bit counts toward stuffing), bit_cnt<=0.
  - S_det in any other state is ignored.
- RECV, on sample with J or K:
  - Decoded bit = 1 if line==prev_line, else 0; prev_line<=line.
  - If ones_cnt==STUFF_LIMIT and bit==0: stuff bit; discard it, ones_cnt<=0.
  - If ones_cnt==STUFF_LIMIT and bit==1: rx_error pulse, go to ERR_WAIT, discard the partial byte.
  - Otherwise: shift in as shreg<={bit,shreg[7:1]}; ones_cnt<=bit?ones_cnt+1:0; bit_cnt++ (3-bit, wraps).
  - When the shifted bit is the 8th (bit_cnt==7): data<=completed byte, rx_valid=1 next cycle, bit_cnt wraps to 0.
  - Latency: rx_valid/data are registered on the edge ending the sample cycle of the 8th bit.
- RECV, on sample with SE0:
  - Go to EOP, se0_cnt<=1.
  - If bit_cnt!=0: partial byte discarded, rx_error pulses in the cycle after this sample.
- EOP:
  - SE0 sample: se0_cnt++ (saturates at EOP_SE0_MIN).
  - J sample with se0_cnt>=EOP_SE0_MIN: eop_det pulse, rx_active<=0, go to IDLE.
  - J sample with se0_cnt<EOP_SE0_MIN, or any K sample: rx_error pulse, go to ERR_WAIT.
- ERR_WAIT:
  - rx_active stays 1; bytes are ignored.
  - SE0 sample: go to EOP, se0_cnt<=1.
  - No second error pulse until EOP is re-entered.
- rx_en=0 in any state: next cycle state=IDLE, rx_active=0; no eop_det or rx_error.
  - Pulses already registered are not cancelled.
- rx_valid, rx_error and eop_det never assert for more than one cycle.
  - rx_valid and rx_error never assert in the same cycle.
- Async reset mid-packet: all outputs return to reset values immediately; resume only on a new S_det.

Decomposition:
- Shared package usb_rx_pkg holds:
  - state encoding IDLE/RECV/EOP/ERR_WAIT;
  - line-state encoding (J/K/SE0);
  - default constants STUFF_LIMIT=6, EOP_SE0_MIN=2.
- One sub-module, usb_nrzi_unstuff:
  - inputs: sample, line, start;
  - outputs: bit_valid, bit, stuff_err;
  - contains NRZI decode and the ones counter.
- The top level keeps the FSM, shift register, bit counter and EOP logic.

Test Plan:
- S_det, then samples K J J K J J K K, SE0 SE0 J -> one rx_valid with data=8'hA5; eop_det one cycle after J sample; rx_active falls with eop_det; rx_error never asserted.
- S_det, then K K K K K J J J J, SE0 SE0 J -> 5 ones hit the limit (sync counted), J discarded as stuff; data=8'hFF, no rx_error.
- S_det, then K K K K K K -> rx_error pulse one cycle after the 6th K, no rx_valid, rx_active stays 1; SE0 SE0 J -> eop_det, rx_active=0.
- S_det, then K J J (3 bits), SE0 SE0 J -> rx_error pulse after the first SE0, no rx_valid, eop_det at end.
- S_det, then 4 valid bits, then rx_en=0 -> rx_active=0 next cycle, no pulses; a subsequent 0xA5 packet received correctly.
- RST low mid-byte -> all outputs 0 immediately; following S_det plus 0xA5 sequence -> data=8'hA5.
